// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
package usb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      STUFF,
      EOP_SE0,
      EOP_J
   } tx_state_t;

   localparam logic [7:0] SYNC_BYTE   = 8'h80;
   localparam logic [2:0] STUFF_LIMIT = 3'd6;

   // Line states as {d_plus, d_minus}
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   // NRZI: a 0 toggles J<->K, a 1 holds the current line state.
   function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
      logic [1:0] nxt;
      nxt = line;
      if (!bit_val) begin
         nxt = (line == LINE_J) ? LINE_K : LINE_J;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Free-running counter 0..rollover_val with a registered flag that is high
// while the count sits at rollover_val.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] count_next;
   logic                    flag_next;

   always_comb begin
      count_next = count_out;
      flag_next  = rollover_flag;
      if (clear) begin
         count_next = '0;
         flag_next  = 1'b0;
      end else if (count_enable) begin
         count_next = (count_out == rollover_val) ? '0 : count_out + 1'b1;
         flag_next  = (count_next == rollover_val);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_out     <= '0;
         rollover_flag <= 1'b0;
      end else begin
         count_out     <= count_next;
         rollover_flag <= flag_next;
      end
   end

endmodule

// File: rtl/usb_tx_encode.sv
// USB full-speed transmit encoder: SYNC insertion, LSB-first serialization,
// bit stuffing, NRZI encoding and EOP generation onto D+/D-.
module usb_tx_encode
   import usb_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       d_plus,
   output logic       d_minus,
   output logic       tx_busy,
   output logic       tx_err
);

   localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   tx_state_t        state, state_n;
   logic [7:0]       shifter, shifter_n, buf_data;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [2:0]       ones_cnt, ones_cnt_n, ones_inc;
   logic             buf_full, buf_full_n, buf_last;
   logic             cur_last, cur_last_n;
   logic             last_taken, last_taken_n;
   logic             accept, load, err_set, err_pend, take_adv, eop_done;
   logic             cnt_clear, cnt_en, bit_strobe, bit_start;
   logic [CNT_W-1:0] bit_cnt;
   logic [1:0]       line_q, line_n;

   tx_state_t        adv_state;
   logic [7:0]       adv_shift;
   logic [2:0]       adv_idx;
   logic             adv_load, adv_err;

   assign cnt_clear = (state == IDLE);
   assign cnt_en    = (state != IDLE);

   flex_counter #(
      .NUM_CNT_BITS(CNT_W)
   ) u_bit_timer (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (cnt_clear),
      .count_enable (cnt_en),
      .rollover_val (BIT_LAST),
      .count_out    (bit_cnt),
      .rollover_flag(bit_strobe)
   );

   // bit_start is the first cycle of a bit; the line register follows one edge later.
   assign bit_start    = (bit_cnt == '0) && (state != IDLE);
   assign accept       = tx_valid & tx_ready;
   assign ones_inc     = shifter[0] ? (ones_cnt + 3'd1) : 3'd0;
   assign eop_done     = (state == EOP_J) && bit_strobe;
   assign buf_full_n   = (buf_full & ~load) | accept;
   assign last_taken_n = (last_taken & ~eop_done) | (accept & tx_last);

   // Leaving a data bit position: next bit, next byte, end of packet or underrun.
   always_comb begin
      adv_state = DATA;
      adv_shift = {1'b0, shifter[7:1]};
      adv_idx   = bit_idx + 3'd1;
      adv_load  = 1'b0;
      adv_err   = 1'b0;
      if (bit_idx == 3'd7) begin
         adv_idx = 3'd0;
         if (cur_last) begin
            adv_state = EOP_SE0;
         end else if (buf_full) begin
            adv_load  = 1'b1;
            adv_shift = buf_data;
         end else begin
            adv_state = EOP_SE0;
            adv_err   = 1'b1;
         end
      end
   end

   always_comb begin
      state_n    = state;
      shifter_n  = shifter;
      bit_idx_n  = bit_idx;
      ones_cnt_n = ones_cnt;
      cur_last_n = cur_last;
      load       = 1'b0;
      err_set    = 1'b0;
      take_adv   = 1'b0;
      case (state)
         IDLE: begin
            if (buf_full || accept) begin
               state_n    = SYNC;
               shifter_n  = SYNC_BYTE;
               bit_idx_n  = 3'd0;
               ones_cnt_n = 3'd0;
            end
         end
         SYNC: begin
            if (bit_strobe) begin
               ones_cnt_n = ones_inc;
               if (bit_idx == 3'd7) begin
                  state_n    = DATA;
                  shifter_n  = buf_data;
                  bit_idx_n  = 3'd0;
                  load       = 1'b1;
                  cur_last_n = buf_last;
               end else begin
                  shifter_n = {1'b0, shifter[7:1]};
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
         DATA: begin
            if (bit_strobe) begin
               ones_cnt_n = ones_inc;
               if (ones_inc == STUFF_LIMIT) begin
                  state_n = STUFF;
               end else begin
                  take_adv = 1'b1;
               end
            end
         end
         STUFF: begin
            // Position was frozen on entry; resume exactly as DATA would have.
            if (bit_strobe) begin
               ones_cnt_n = 3'd0;
               take_adv   = 1'b1;
            end
         end
         EOP_SE0: begin
            if (bit_strobe) begin
               if (bit_idx == 3'd1) begin
                  state_n   = EOP_J;
                  bit_idx_n = 3'd0;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
         EOP_J: begin
            if (bit_strobe) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (take_adv) begin
         state_n   = adv_state;
         shifter_n = adv_shift;
         bit_idx_n = adv_idx;
         load      = adv_load;
         err_set   = adv_err;
         if (adv_load) begin
            cur_last_n = buf_last;
         end
      end
   end

   always_comb begin
      line_n = line_q;
      if (state == IDLE) begin
         line_n = LINE_J;
      end else if (bit_start) begin
         case (state)
            SYNC, DATA: line_n = nrzi_next(line_q, shifter[0]);
            STUFF:      line_n = nrzi_next(line_q, 1'b0);
            EOP_SE0:    line_n = LINE_SE0;
            default:    line_n = LINE_J;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         bit_idx    <= 3'd0;
         ones_cnt   <= 3'd0;
         buf_full   <= 1'b0;
         buf_last   <= 1'b0;
         cur_last   <= 1'b0;
         last_taken <= 1'b0;
         err_pend   <= 1'b0;
         tx_err     <= 1'b0;
         tx_busy    <= 1'b0;
         tx_ready   <= 1'b1;
         line_q     <= LINE_J;
      end else begin
         state      <= state_n;
         bit_idx    <= bit_idx_n;
         ones_cnt   <= ones_cnt_n;
         buf_full   <= buf_full_n;
         cur_last   <= cur_last_n;
         last_taken <= last_taken_n;
         err_pend   <= err_set;
         tx_err     <= err_pend;
         tx_busy    <= (state != IDLE);
         tx_ready   <= ~buf_full_n & ~last_taken_n;
         line_q     <= line_n;
         if (accept) begin
            buf_last <= tx_last;
         end
      end
   end

   always_ff @(posedge clk) begin
      shifter <= shifter_n;
      if (accept) begin
         buf_data <= tx_data;
      end
   end

   assign d_plus  = line_q[1];
   assign d_minus = line_q[0];

endmodule

// File: tb/tb_usb_tx_encode.sv
// Directed bench for usb_tx_encode: table of packets with hand-derived D+ bit
// sequences, plus reset-mid-packet and handshake sequences.
module tb_usb_tx_encode;

   localparam int         CPB  = 8;
   localparam int         NV   = 7;
   localparam logic [1:0] LJ   = 2'b10;
   localparam logic [1:0] LK   = 2'b01;
   localparam logic [1:0] LSE0 = 2'b00;

   typedef struct packed {
      int          nb;
      logic [23:0] bytes;
      logic        last;
      logic [39:0] dp;
      int          nbits;
      logic        exp_err;
      logic        exp_rdy;
   } tvec_t;

   logic       tb_clk = 1'b0;
   logic       n_rst  = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready, d_plus, d_minus, tx_busy, tx_err;
   logic [1:0] line;

   int    n_checks = 0;
   int    n_pass   = 0;
   int    cyc      = 0;
   int    err_cnt  = 0;
   int    acc_cyc  = 0;
   int    busy_cyc = 0;
   int    err_base = 0;
   tvec_t vecs [NV];

   usb_tx_encode #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (tb_clk),
      .n_rst   (n_rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_last (tx_last),
      .tx_ready(tx_ready),
      .d_plus  (d_plus),
      .d_minus (d_minus),
      .tx_busy (tx_busy),
      .tx_err  (tx_err)
   );

   assign line = {d_plus, d_minus};

   always #5 tb_clk = ~tb_clk;
   always @(posedge tb_clk) cyc <= cyc + 1;
   always @(negedge tb_clk) if (tx_err) err_cnt <= err_cnt + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail_note(input string name);
      n_checks++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   function automatic logic [39:0] seq(input string s);
      logic [39:0] r;
      r = '0;
      for (int i = 0; i < s.len(); i++) r[i] = (s.getc(i) == 8'h31);
      return r;
   endfunction

   task automatic add_vec(input int idx, input int nb, input logic [23:0] bytes, input logic last,
                          input string s, input logic err, input logic rdy);
      vecs[idx].nb      = nb;
      vecs[idx].bytes   = bytes;
      vecs[idx].last    = last;
      vecs[idx].dp      = seq(s);
      vecs[idx].nbits   = s.len();
      vecs[idx].exp_err = err;
      vecs[idx].exp_rdy = rdy;
   endtask

   // Called at posedge+1; returns at posedge+1 after the final accept.
   task automatic feed(input int v, input int nb, input logic [23:0] bytes, input logic last);
      int g;
      for (int i = 0; i < nb; i++) begin
         tx_valid = 1'b1;
         tx_data  = bytes[8*i +: 8];
         tx_last  = last && (i == nb - 1);
         g = 0;
         while (!tx_ready && g < 3000) begin
            @(posedge tb_clk); #1;
            g++;
         end
         if (!tx_ready) begin
            fail_note($sformatf("v%0d ready wait byte%0d", v, i));
            break;
         end
         @(posedge tb_clk); #1;
         if (i == 0) acc_cyc = cyc;
         chk($sformatf("v%0d ready low after byte%0d", v, i), tx_ready, 1'b0);
      end
      tx_valid = 1'b0;
      tx_last  = 1'b0;
   endtask

   // Checks the first and last cycle of one bit time, ends at the next bit's first cycle.
   task automatic hold_bit(input string name, input logic [1:0] ex);
      chk({name, " start"}, line, ex);
      repeat (CPB - 1) @(posedge tb_clk);
      #1;
      chk({name, " end"}, line, ex);
      @(posedge tb_clk); #1;
   endtask

   task automatic check_packet(input int v, input tvec_t t, output int bcyc);
      int g;
      bcyc = -1;
      g = 0;
      while (!tx_busy && g < 400) begin
         @(posedge tb_clk); #1;
         g++;
      end
      if (!tx_busy) begin
         fail_note($sformatf("v%0d busy rise", v));
         return;
      end
      bcyc = cyc;
      for (int i = 0; i < t.nbits; i++)
         hold_bit($sformatf("v%0d bit%0d", v, i), t.dp[i] ? LJ : LK);
      chk($sformatf("v%0d err at SE0", v), tx_err, t.exp_err);
      chk($sformatf("v%0d ready at SE0", v), tx_ready, t.exp_rdy);
      hold_bit($sformatf("v%0d se0a", v), LSE0);
      hold_bit($sformatf("v%0d se0b", v), LSE0);
      chk($sformatf("v%0d eopj start", v), line, LJ);
      repeat (CPB - 1) @(posedge tb_clk);
      #1;
      chk($sformatf("v%0d eopj end", v), line, LJ);
      chk($sformatf("v%0d busy in eopj", v), tx_busy, 1'b1);
      @(posedge tb_clk); #1;
      chk($sformatf("v%0d busy fall", v), tx_busy, 1'b0);
      chk($sformatf("v%0d idle line", v), line, LJ);
      chk($sformatf("v%0d idle ready", v), tx_ready, 1'b1);
   endtask

   initial begin
      int bcyc, se0_seen, busy_seen;

      add_vec(0, 1, 24'h000000, 1'b1, {"01010100", "10101010"}, 1'b0, 1'b0);
      add_vec(1, 1, 24'h0000FF, 1'b1, {"01010100", "00000", "1", "111"}, 1'b0, 1'b0);
      add_vec(2, 1, 24'h0000FC, 1'b1, {"01010100", "10000000", "1"}, 1'b0, 1'b0);
      add_vec(3, 2, 24'h00C3FC, 1'b1, {"01010100", "10000000", "1", "11010111"}, 1'b0, 1'b0);
      add_vec(4, 2, 24'h00C33F, 1'b1, {"01010100", "00000", "1", "101", "11010111"}, 1'b0, 1'b0);
      add_vec(5, 1, 24'h000055, 1'b0, {"01010100", "01100110"}, 1'b1, 1'b1);
      add_vec(6, 3, 24'h00FF00, 1'b1,
              {"01010100", "10101010", "000000", "1", "11", "01010101"}, 1'b0, 1'b0);

      #2 n_rst = 1'b0;
      #1;
      chk("reset line", line, LJ);
      chk("reset ready", tx_ready, 1'b1);
      chk("reset busy", tx_busy, 1'b0);
      chk("reset err", tx_err, 1'b0);
      repeat (3) @(posedge tb_clk);
      @(negedge tb_clk) n_rst = 1'b1;
      @(posedge tb_clk); #1;
      chk("idle line", line, LJ);

      for (int v = 0; v < NV; v++) begin
         err_base = err_cnt;
         fork
            feed(v, vecs[v].nb, vecs[v].bytes, vecs[v].last);
            check_packet(v, vecs[v], bcyc);
         join
         busy_cyc = bcyc;
         chk($sformatf("v%0d busy latency", v), busy_cyc - acc_cyc, 1);
         repeat (2) @(posedge tb_clk);
         #1;
         chk($sformatf("v%0d err pulses", v), err_cnt - err_base, {31'd0, vecs[v].exp_err});
      end

      // Reset in the middle of SYNC: line goes to J at once, no EOP follows.
      err_base = err_cnt;
      feed(99, 1, 24'h000000, 1'b1);
      repeat (20) @(posedge tb_clk);
      #3 n_rst = 1'b0;
      #1;
      chk("midreset line", line, LJ);
      chk("midreset busy", tx_busy, 1'b0);
      chk("midreset ready", tx_ready, 1'b1);
      @(negedge tb_clk) n_rst = 1'b1;
      se0_seen  = 0;
      busy_seen = 0;
      repeat (200) begin
         @(posedge tb_clk); #1;
         if (line == LSE0) se0_seen++;
         if (tx_busy) busy_seen++;
      end
      chk("midreset no SE0", se0_seen, 0);
      chk("midreset no busy", busy_seen, 0);
      chk("midreset no err", err_cnt - err_base, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
